// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package pipeline_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

    // A later stage supplies a source operand when it writes a non-x0 register with that index.
    function automatic logic reg_hit(input logic [REG_W-1:0] rd,
                                     input logic             we,
                                     input logic [REG_W-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-control bus between the datapath (master) and pipeline_ctrl (slave).
interface pipeline_ctrl_if import pipeline_pkg::*; #(
    parameter int CNT_W = 16
) ();
    logic [REG_W-1:0] Rs1D, Rs2D;
    logic [REG_W-1:0] Rs1E, Rs2E, RdE;
    logic             ResultSrcE;
    logic             PCSrcE;
    logic [REG_W-1:0] RdM;
    logic             RegWriteM;
    logic [REG_W-1:0] RdW;
    logic             RegWriteW;
    logic             MemReqM;
    logic             MemReadyM;

    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    fwd_sel_t         ForwardAE, ForwardBE;
    logic             MemTimeout;
    logic [CNT_W-1:0] StallCycles;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               RdM, RegWriteM, RdW, RegWriteW, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemTimeout, StallCycles
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               RdM, RegWriteM, RdW, RegWriteW, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemTimeout, StallCycles
    );
endinterface

// File: rtl/pipeline_ctrl_forward_unit.sv
// Operand bypass select for one Execute-stage source register; MEM beats WB.
module forward_unit import pipeline_pkg::*; (
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rd_m_i,
    input  logic             regwrite_m_i,
    input  logic [REG_W-1:0] rd_w_i,
    input  logic             regwrite_w_i,
    output fwd_sel_t         fwd_o
);

    // Youngest producer wins so the operand sees the most recent write.
    always_comb begin
        fwd_o = FWD_NONE;
        if (reg_hit(rd_m_i, regwrite_m_i, rs_i))
            fwd_o = FWD_MEM;
        else if (reg_hit(rd_w_i, regwrite_w_i, rs_i))
            fwd_o = FWD_WB;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush,
// data-memory wait freeze with timeout, and a saturating stall counter.
module pipeline_ctrl import pipeline_pkg::*; #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    pipeline_ctrl_if.slave bus
);

    // Guard against a zero-width counter when TIMEOUT is illegal; the check below reports it.
    localparam int WCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("pipeline_ctrl: TIMEOUT must be at least 1");
    end

    ctrl_state_t       state_q;
    logic [WCNT_W-1:0] wait_cnt_q;
    logic              mem_timeout_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic freeze;
    logic lwstall;

    forward_unit u_fwd_a (
        .rs_i         (bus.Rs1E),
        .rd_m_i       (bus.RdM),
        .regwrite_m_i (bus.RegWriteM),
        .rd_w_i       (bus.RdW),
        .regwrite_w_i (bus.RegWriteW),
        .fwd_o        (bus.ForwardAE)
    );

    forward_unit u_fwd_b (
        .rs_i         (bus.Rs2E),
        .rd_m_i       (bus.RdM),
        .regwrite_m_i (bus.RegWriteM),
        .rd_w_i       (bus.RdW),
        .regwrite_w_i (bus.RegWriteW),
        .fwd_o        (bus.ForwardBE)
    );

    // Freeze and hazard decode; freeze overrides flushes so a pending branch or
    // load-use in E is simply replayed in the first unfrozen cycle. Reset drops
    // the freeze combinationally so the pipe releases in the reset cycle itself.
    always_comb begin
        freeze = 1'b0;
        unique case (state_q)
            RUN:      freeze = bus.MemReqM && !bus.MemReadyM;
            MEM_WAIT: freeze = !bus.MemReadyM;
            ERROR:    freeze = 1'b1;
            default:  freeze = 1'b0;
        endcase
        if (rst)
            freeze = 1'b0;

        lwstall = bus.ResultSrcE && (bus.RdE != '0) &&
                  ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D)) && !bus.PCSrcE;

        bus.StallF = freeze || lwstall;
        bus.StallD = freeze || lwstall;
        bus.StallE = freeze;
        bus.StallM = freeze;
        bus.FlushD = !freeze && bus.PCSrcE;
        bus.FlushE = !freeze && (bus.PCSrcE || lwstall);
        bus.FlushW = freeze;
    end

    // Memory wait FSM with timeout; ERROR only leaves through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.MemReqM && !bus.MemReadyM) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (bus.MemReadyM) begin
                        state_q <= RUN;
                    end else if (wait_cnt_q == WCNT_LAST) begin
                        state_q       <= ERROR;
                        mem_timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ERROR: begin
                    mem_timeout_q <= 1'b1;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    // Stall counter holds at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.StallF && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Performance counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign bus.MemTimeout  = mem_timeout_q;
    assign bus.StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_pipeline_ctrl;
    localparam int TO    = 4;
    localparam int CW    = 4;
    localparam int SATV  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pipeline_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit m_err    = 1'b0;  // timed out, waiting for reset
    bit m_inwait = 1'b0;  // an unfinished memory access is holding the pipe
    int m_frozen = 0;     // frozen cycles in the current memory episode
    int m_stalls = 0;     // cycles seen with StallF high, clamped

    function automatic bit exp_freeze();
        if (rst) return 1'b0;
        return m_err || (!bus.MemReadyM && (m_inwait || bus.MemReqM));
    endfunction

    function automatic bit exp_lu();
        return bus.ResultSrcE && bus.RdE != 0 &&
               (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D) && !bus.PCSrcE;
    endfunction

    function automatic int exp_fwd(input logic [4:0] rs);
        logic [4:0] rd [2];
        logic       we [2];
        rd[0] = bus.RdM; we[0] = bus.RegWriteM;
        rd[1] = bus.RdW; we[1] = bus.RegWriteW;
        for (int s = 0; s < 2; s++)
            if (we[s] && rd[s] != 0 && rd[s] == rs)
                return (s == 0) ? 2 : 1;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_err = 0; m_inwait = 0; m_frozen = 0; m_stalls = 0;
        end else begin
            bit f;
            f = exp_freeze();
            if ((f || exp_lu()) && m_stalls < SATV) m_stalls++;
            if (!m_err) begin
                if (f) begin
                    m_frozen++;
                    m_inwait = 1;
                    if (m_frozen == TO + 1) m_err = 1;
                end else begin
                    m_frozen = 0;
                    m_inwait = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit f, lu;
        f  = exp_freeze();
        lu = exp_lu();
        chk("m_StallF", 32'(bus.StallF), 32'(f || lu));
        chk("m_StallD", 32'(bus.StallD), 32'(f || lu));
        chk("m_StallE", 32'(bus.StallE), 32'(f));
        chk("m_StallM", 32'(bus.StallM), 32'(f));
        chk("m_FlushD", 32'(bus.FlushD), 32'(!f && bus.PCSrcE));
        chk("m_FlushE", 32'(bus.FlushE), 32'(!f && (bus.PCSrcE || lu)));
        chk("m_FlushW", 32'(bus.FlushW), 32'(f));
        chk("m_FwdA",   32'(bus.ForwardAE), 32'(exp_fwd(bus.Rs1E)));
        chk("m_FwdB",   32'(bus.ForwardBE), 32'(exp_fwd(bus.Rs2E)));
        chk("m_Tmo",    32'(bus.MemTimeout), 32'(m_err));
        chk("m_Cnt",    32'(bus.StallCycles), 32'(m_stalls));
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic clr();
        bus.Rs1D = 0; bus.Rs2D = 0; bus.Rs1E = 0; bus.Rs2E = 0; bus.RdE = 0;
        bus.ResultSrcE = 0; bus.PCSrcE = 0; bus.RdM = 0; bus.RegWriteM = 0;
        bus.RdW = 0; bus.RegWriteW = 0; bus.MemReqM = 0; bus.MemReadyM = 0;
    endtask

    task automatic rst_pulse();
        cyc(); clr(); rst = 1;
        cyc(); rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        // Reset state
        @(negedge clk);
        chk("rst_StallF", 32'(bus.StallF), 0);
        chk("rst_FlushE", 32'(bus.FlushE), 0);
        chk("rst_FlushW", 32'(bus.FlushW), 0);
        chk("rst_FwdA", 32'(bus.ForwardAE), 0);
        chk("rst_Tmo", 32'(bus.MemTimeout), 0);
        chk("rst_Cnt", 32'(bus.StallCycles), 0);
        cyc(); rst = 0;

        // Forwarding priority
        cyc(); bus.RegWriteM = 1; bus.RdM = 5; bus.RegWriteW = 1; bus.RdW = 5; bus.Rs1E = 5; bus.Rs2E = 0;
        @(negedge clk);
        chk("fwd_A_mem", 32'(bus.ForwardAE), 32'h2);
        chk("fwd_B_none", 32'(bus.ForwardBE), 32'h0);
        cyc(); bus.RegWriteM = 0;
        @(negedge clk);
        chk("fwd_A_wb", 32'(bus.ForwardAE), 32'h1);

        // Load-use, then with a taken branch
        cyc(); clr(); bus.ResultSrcE = 1; bus.RdE = 7; bus.Rs2D = 7;
        @(negedge clk);
        chk("lu_StallF", 32'(bus.StallF), 1);
        chk("lu_StallD", 32'(bus.StallD), 1);
        chk("lu_FlushE", 32'(bus.FlushE), 1);
        cyc(); bus.PCSrcE = 1;
        @(negedge clk);
        chk("br_StallF", 32'(bus.StallF), 0);
        chk("br_StallD", 32'(bus.StallD), 0);
        chk("br_FlushD", 32'(bus.FlushD), 1);
        chk("br_FlushE", 32'(bus.FlushE), 1);

        // Memory wait of three cycles
        rst_pulse();
        cyc(); bus.MemReqM = 1; bus.MemReadyM = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mw_StallF", 32'(bus.StallF), 1);
            chk("mw_StallM", 32'(bus.StallM), 1);
            chk("mw_FlushW", 32'(bus.FlushW), 1);
            cyc();
        end
        bus.MemReadyM = 1;
        @(negedge clk);
        chk("mw_rel_StallF", 32'(bus.StallF), 0);
        chk("mw_rel_StallE", 32'(bus.StallE), 0);
        cyc(); clr();
        @(negedge clk);
        chk("mw_Cnt", 32'(bus.StallCycles), 3);

        // Branch held during a freeze
        cyc(); bus.MemReqM = 1; bus.PCSrcE = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bf_FlushD", 32'(bus.FlushD), 0);
            chk("bf_FlushE", 32'(bus.FlushE), 0);
            cyc();
        end
        bus.MemReadyM = 1;
        @(negedge clk);
        chk("bf_rel_FlushD", 32'(bus.FlushD), 1);
        chk("bf_rel_FlushE", 32'(bus.FlushE), 1);

        // Timeout: five frozen cycles, then ERROR
        rst_pulse();
        cyc(); bus.MemReqM = 1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("to_StallF", 32'(bus.StallF), 1);
            chk("to_Tmo_pre", 32'(bus.MemTimeout), 0);
            cyc();
        end
        @(negedge clk);
        chk("to_Tmo", 32'(bus.MemTimeout), 1);
        cyc(); bus.MemReadyM = 1; bus.MemReqM = 0;
        @(negedge clk);
        chk("to_Tmo_sticky", 32'(bus.MemTimeout), 1);
        chk("to_err_StallF", 32'(bus.StallF), 1);
        chk("to_err_FlushW", 32'(bus.FlushW), 1);
        #2 rst = 1;
        #1;
        chk("to_rst_Tmo", 32'(bus.MemTimeout), 0);
        chk("to_rst_StallF", 32'(bus.StallF), 0);
        cyc(); rst = 0; clr();

        // Asynchronous reset in the middle of MEM_WAIT
        cyc(); bus.MemReqM = 1;
        cyc(); cyc();
        @(negedge clk);
        chk("ar_pre_StallM", 32'(bus.StallM), 1);
        #2 rst = 1;
        #1;
        chk("ar_StallF", 32'(bus.StallF), 0);
        chk("ar_StallE", 32'(bus.StallE), 0);
        chk("ar_StallM", 32'(bus.StallM), 0);
        chk("ar_FlushW", 32'(bus.FlushW), 0);
        bus.MemReqM = 0;
        cyc(); rst = 0;

        // Saturation after 20 stall cycles
        cyc(); bus.ResultSrcE = 1; bus.RdE = 7; bus.Rs2D = 7;
        repeat (20) cyc();
        clr();
        @(negedge clk);
        chk("sat_Cnt", 32'(bus.StallCycles), 32'(SATV));

        // Randomized run
        rst_pulse();
        for (int n = 0; n < 3000; n++) begin
            cyc();
            bus.Rs1D = 5'($urandom_range(0, 3)); bus.Rs2D = 5'($urandom_range(0, 3));
            bus.Rs1E = 5'($urandom_range(0, 3)); bus.Rs2E = 5'($urandom_range(0, 3));
            bus.RdE  = 5'($urandom_range(0, 3)); bus.RdM  = 5'($urandom_range(0, 3));
            bus.RdW  = 5'($urandom_range(0, 3));
            bus.RegWriteM  = 1'($urandom_range(0, 1));
            bus.RegWriteW  = 1'($urandom_range(0, 1));
            bus.ResultSrcE = ($urandom_range(0, 2) == 0);
            bus.PCSrcE     = ($urandom_range(0, 5) == 0);
            bus.MemReqM    = ($urandom_range(0, 2) == 0);
            bus.MemReadyM  = 1'($urandom_range(0, 1));
            rst            = ($urandom_range(0, 99) == 0);
        end
        cyc(); rst = 0; clr();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
